// File: rtl/tnn_serial_classifier.sv
// tnn_serial_classifier: accumulates a 7-beat 2-bit feature frame into positive/negative
// weight sums and holds a registered class decision until the consumer takes it.
module tnn_serial_classifier (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_data,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_class,
    output logic [3:0]  out_pos_sum,
    output logic [3:0]  out_neg_sum,
    output logic        out_err,
    output logic [15:0] frame_cnt
);
    typedef enum logic {ACCUM, HOLD} state_t;
    state_t      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [3:0]  pos_q, pos_d, neg_q, neg_d, opos_q, opos_d, oneg_q, oneg_d;
    logic        err_q, err_d, ocls_q, ocls_d, oerr_q, oerr_d;
    logic [15:0] cnt_q, cnt_d;
    logic        acc, fin, is_pos;
    always_comb begin
        acc     = in_valid && state_q == ACCUM;
        fin     = acc && idx_q == 3'd6;
        is_pos  = !idx_q[0] && idx_q != 3'd6;
        state_d = state_q;
        idx_d   = idx_q;
        pos_d   = pos_q;
        neg_d   = neg_q;
        err_d   = err_q;
        opos_d  = opos_q;
        oneg_d  = oneg_q;
        ocls_d  = ocls_q;
        oerr_d  = oerr_q;
        cnt_d   = cnt_q;
        if (acc) begin
            idx_d = fin ? 3'd0 : idx_q + 3'd1;
            pos_d = is_pos ? pos_q + {2'b00, in_data} : pos_q;
            neg_d = is_pos ? neg_q : neg_q + {2'b00, in_data};
            // in_last must coincide exactly with the seventh beat
            err_d = err_q | (in_last ^ (idx_q == 3'd6));
        end
        if (fin) begin
            state_d = HOLD;
            opos_d  = pos_d;
            oneg_d  = neg_d;
            ocls_d  = pos_d > neg_d;
            oerr_d  = err_d;
        end
        if (state_q == HOLD && out_ready) begin
            state_d = ACCUM;
            idx_d   = 3'd0;
            pos_d   = 4'd0;
            neg_d   = 4'd0;
            err_d   = 1'b0;
            cnt_d   = cnt_q + 16'd1;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ACCUM;
            idx_q   <= 3'd0;
            pos_q   <= 4'd0;
            neg_q   <= 4'd0;
            err_q   <= 1'b0;
            opos_q  <= 4'd0;
            oneg_q  <= 4'd0;
            ocls_q  <= 1'b0;
            oerr_q  <= 1'b0;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pos_q   <= pos_d;
            neg_q   <= neg_d;
            err_q   <= err_d;
            opos_q  <= opos_d;
            oneg_q  <= oneg_d;
            ocls_q  <= ocls_d;
            oerr_q  <= oerr_d;
            cnt_q   <= cnt_d;
        end
    end
    assign in_ready    = state_q == ACCUM;
    assign out_valid   = state_q == HOLD;
    assign out_class   = ocls_q;
    assign out_pos_sum = opos_q;
    assign out_neg_sum = oneg_q;
    assign out_err     = oerr_q;
    assign frame_cnt   = cnt_q;
endmodule
